// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - opcodes, FSM encoding and width helpers for the accumulator CPU
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_IN  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_RSV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Instruction word is a 4-bit opcode above a DATA_W-wide immediate.
    function automatic int calc_iw(input int data_w);
        return 4 + data_w;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - combinational ALU producing the new accumulator and carry
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] ext_in,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              carry_we,
    output logic              acc_we
);

    logic [DATA_W:0] wide;

    always_comb begin
        result    = acc;
        carry_out = 1'b0;
        carry_we  = 1'b0;
        acc_we    = 1'b0;
        wide      = '0;
        case (opcode)
            OP_LDI: begin result = imm; acc_we = 1'b1; end
            OP_ADD: begin
                wide      = {1'b0, acc} + {1'b0, imm};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
                carry_we  = 1'b1;
                acc_we    = 1'b1;
            end
            // The extra top bit of the widened difference is the borrow.
            OP_SUB: begin
                wide      = {1'b0, acc} - {1'b0, imm};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
                carry_we  = 1'b1;
                acc_we    = 1'b1;
            end
            OP_AND: begin result = acc & imm; acc_we = 1'b1; end
            OP_OR:  begin result = acc | imm; acc_we = 1'b1; end
            OP_XOR: begin result = acc ^ imm; acc_we = 1'b1; end
            OP_SHL: begin
                result    = acc << 1;
                carry_out = acc[DATA_W-1];
                carry_we  = 1'b1;
                acc_we    = 1'b1;
            end
            OP_SHR: begin
                result    = acc >> 1;
                carry_out = acc[0];
                carry_we  = 1'b1;
                acc_we    = 1'b1;
            end
            OP_IN:  begin result = ext_in; acc_we = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// rtl/acc_cpu_param.sv - parametrised accumulator CPU with run/step/halt control
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int IW     = calc_iw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              run,
    input  logic              step,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic              acc_we,
    input  logic [DATA_W-1:0] acc_din,
    input  logic [DATA_W-1:0] ext_in,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              zero,
    output logic              carry,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [IW-1:0]     prog_mem [DEPTH];
    state_t            state;
    logic [IW-1:0]     instr;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_carry_we;
    logic              alu_acc_we;
    logic              host_write;
    logic              exec;

    assign instr  = prog_mem[pc];
    assign opcode = instr[IW-1:DATA_W];
    assign imm    = instr[DATA_W-1:0];
    assign busy   = (state == ST_RUN);
    assign halted = (state == ST_HALT);

    // Host writes only land while the core is stopped, and they pre-empt run/step.
    assign host_write = (state != ST_RUN) && (prog_we || acc_we);
    assign exec = !clear && !host_write &&
                  (((state == ST_RUN) && run) || ((state == ST_IDLE) && step && !run));

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc       (acc),
        .imm       (imm),
        .ext_in    (ext_in),
        .opcode    (opcode),
        .result    (alu_result),
        .carry_out (alu_carry),
        .carry_we  (alu_carry_we),
        .acc_we    (alu_acc_we)
    );

    always_comb begin
        next_pc = pc + 1'b1;
        case (opcode)
            OP_JMP: next_pc = imm[ADDR_W-1:0];
            OP_JZ:  if (zero)  next_pc = imm[ADDR_W-1:0];
            OP_JC:  if (carry) next_pc = imm[ADDR_W-1:0];
            OP_HLT: next_pc = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            pc        <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) prog_mem[ADDR_W'(i)] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                acc      <= '0;
                pc       <= '0;
                zero     <= 1'b0;
                carry    <= 1'b0;
                out_data <= '0;
            end else if (host_write) begin
                if (prog_we) prog_mem[prog_addr] <= prog_data;
                if (acc_we)  acc <= acc_din;
            end else begin
                case (state)
                    ST_IDLE: if (run)  state <= ST_RUN;
                    ST_RUN:  if (!run) state <= ST_IDLE;
                    default: ;
                endcase
                if (exec) begin
                    if (alu_acc_we) begin
                        acc  <= alu_result;
                        zero <= (alu_result == '0);
                    end
                    if (alu_carry_we) carry <= alu_carry;
                    if (opcode == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                    pc <= next_pc;
                    if (opcode == OP_HLT) state <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb/tb_acc_cpu_param.sv - self-checking bench for acc_cpu_param
module tb_acc_cpu_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       acc_we = 1'b0;
    logic [3:0] acc_din = '0;
    logic [3:0] ext_in = '0;
    logic [3:0] acc;
    logic [3:0] pc;
    logic       zero;
    logic       carry;
    logic [3:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       halted;

    int checks = 0;
    int errors = 0;
    logic [3:0] out_q[$];

    typedef struct {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] acc_init;
        logic [3:0] ext;
        logic [3:0] exp_acc;
        logic       exp_z;
        logic       exp_c;
    } vec_t;
    vec_t vecs[15];

    acc_cpu_param #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .run       (run),
        .step      (step),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .acc_we    (acc_we),
        .acc_din   (acc_din),
        .ext_in    (ext_in),
        .acc       (acc),
        .pc        (pc),
        .zero      (zero),
        .carry     (carry),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] op, input logic [3:0] imm);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = {op, imm};
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic run_to_halt(input int max, output int n, output int ov_n, output int subs);
        n = 0;
        ov_n = -1;
        subs = 0;
        run = 1'b1;
        while (!halted && n < max) begin
            tick();
            n++;
            if (out_valid) ov_n = n;
            if (busy && pc == 4'd1) subs++;
        end
        check("halt_within_bound", halted, 1);
        run = 1'b0;
    endtask

    // Output scoreboard: every OUT pulse must match the oldest expected value.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && out_valid) begin
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=%0h required=none", out_data);
            end else begin
                e = out_q.pop_front();
                check("out_data", out_data, e);
            end
        end
    end

    initial begin
        int n, ov_n, subs, busy_seen;
        logic [3:0] exp_pc;

        vecs[0]  = '{4'h1, 4'h5, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 4'hC, 4'h7, 4'h0, 4'h3, 1'b0, 1'b1};
        vecs[2]  = '{4'h4, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[3]  = '{4'h2, 4'h1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[4]  = '{4'h3, 4'h3, 4'h2, 4'h0, 4'hF, 1'b0, 1'b1};
        vecs[5]  = '{4'h3, 4'h2, 4'h5, 4'h0, 4'h3, 1'b0, 1'b0};
        vecs[6]  = '{4'h5, 4'hA, 4'h5, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[7]  = '{4'h6, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[8]  = '{4'h7, 4'h0, 4'h9, 4'h0, 4'h2, 1'b0, 1'b1};
        vecs[9]  = '{4'h8, 4'h0, 4'h5, 4'h0, 4'h2, 1'b0, 1'b1};
        vecs[10] = '{4'h8, 4'h0, 4'h4, 4'h0, 4'h2, 1'b0, 1'b0};
        vecs[11] = '{4'h9, 4'h0, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[12] = '{4'h0, 4'h0, 4'h6, 4'h0, 4'h6, 1'b1, 1'b0};
        vecs[13] = '{4'hE, 4'h0, 4'h3, 4'h0, 4'h3, 1'b1, 1'b0};
        vecs[14] = '{4'h7, 4'h0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b1};

        #12;
        check("rst_acc", acc, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: load acc, place one instruction at pc, single-step it.
        do_clear();
        exp_pc = 4'd0;
        for (int i = 0; i < 15; i++) begin
            prog_we   = 1'b1;
            prog_addr = exp_pc;
            prog_data = {vecs[i].op, vecs[i].imm};
            acc_we    = 1'b1;
            acc_din   = vecs[i].acc_init;
            ext_in    = vecs[i].ext;
            tick();
            prog_we = 1'b0;
            acc_we  = 1'b0;
            step = 1'b1;
            tick();
            step = 1'b0;
            exp_pc = exp_pc + 4'd1;
            check($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_z);
            check($sformatf("vec%0d_carry", i), carry, vecs[i].exp_c);
            check($sformatf("vec%0d_pc", i), pc, exp_pc);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Add with carry, OUT, HLT.
        do_clear();
        wr(4'd0, 4'h1, 4'd7);
        wr(4'd1, 4'h2, 4'd12);
        wr(4'd2, 4'hA, 4'd0);
        wr(4'd3, 4'hF, 4'd0);
        out_q.push_back(4'd3);
        run_to_halt(20, n, ov_n, subs);
        check("add_acc", acc, 3);
        check("add_carry", carry, 1);
        check("add_zero", zero, 0);
        check("add_pc", pc, 3);
        check("add_out_cycle", ov_n, 4);
        check("add_halt_cycle", n, 5);
        tick();
        check("halt_holds", halted, 1);

        // Clear from HALT keeps the program.
        do_clear();
        check("clr_halted", halted, 0);
        check("clr_busy", busy, 0);
        check("clr_pc", pc, 0);
        check("clr_acc", acc, 0);
        check("clr_out_data", out_data, 0);
        out_q.push_back(4'd3);
        run_to_halt(20, n, ov_n, subs);
        check("rerun_acc", acc, 3);
        check("rerun_halt_cycle", n, 5);

        // Countdown loop.
        do_clear();
        wr(4'd0, 4'h1, 4'd3);
        wr(4'd1, 4'h3, 4'd1);
        wr(4'd2, 4'hC, 4'd4);
        wr(4'd3, 4'hB, 4'd1);
        wr(4'd4, 4'hF, 4'd0);
        run_to_halt(40, n, ov_n, subs);
        check("cd_acc", acc, 0);
        check("cd_zero", zero, 1);
        check("cd_carry", carry, 0);
        check("cd_pc", pc, 4);
        check("cd_sub_count", subs, 3);
        check("cd_cycles_to_halt", n, 11);

        // Reset in the middle of a run, then confirm every word reads back as NOP.
        do_clear();
        run = 1'b1;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_acc", acc, 0);
        check("rstmid_pc", pc, 0);
        check("rstmid_zero", zero, 0);
        check("rstmid_carry", carry, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_halted", halted, 0);
        run = 1'b0;
        tick();
        rst = 1'b0;
        run = 1'b1;
        repeat (17) tick();
        run = 1'b0;
        tick();
        check("nop_acc", acc, 0);
        check("nop_zero", zero, 0);
        check("nop_pc", pc, 0);
        check("nop_halted", halted, 0);

        // Single step.
        do_clear();
        ext_in = 4'd9;
        wr(4'd0, 4'h9, 4'd0);
        wr(4'd1, 4'h7, 4'd0);
        busy_seen = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        if (busy) busy_seen = 1;
        check("step1_acc", acc, 9);
        tick();
        if (busy) busy_seen = 1;
        step = 1'b1;
        tick();
        step = 1'b0;
        if (busy) busy_seen = 1;
        check("step2_acc", acc, 2);
        check("step2_carry", carry, 1);
        check("step2_pc", pc, 2);
        check("step_busy_never", busy_seen, 0);

        // PC wrap over an all-NOP program.
        do_clear();
        for (int i = 0; i < 16; i++) wr(i[3:0], 4'h0, 4'd0);
        run = 1'b1;
        tick();
        check("wrap_transition_pc", pc, 0);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("wrap_pc%0d", i), pc, i % 16);
            tick();
        end

        // Write during RUN is dropped; dropping run freezes pc.
        prog_we   = 1'b1;
        prog_addr = 4'd5;
        prog_data = {4'h1, 4'd9};
        tick();
        prog_we = 1'b0;
        run = 1'b0;
        tick();
        check("drop_pc", pc, 2);
        check("drop_busy", busy, 0);
        repeat (3) tick();
        check("frozen_pc", pc, 2);
        run = 1'b1;
        repeat (7) tick();
        run = 1'b0;
        tick();
        check("runwrite_pc", pc, 8);
        check("runwrite_ignored_acc", acc, 0);

        check("out_queue_empty", out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
